// File: rtl/apb_pkg.sv
// Shared APB arbiter types: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int APB_AW = 4;
  localparam int APB_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; combinational grant, pointer advances past the winner on an enabled grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       any_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = ptr_q ? 2'b10 : 2'b01;
  end

  assign any_o = |req_i;

  // Winner 0 hands preference to 1 and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (enable_i && any_o) ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, PREADY wait with timeout abort.
// All outputs registered; back-to-back transfers every 2 cycles with a zero-wait slave.
module apb_mem_arbiter
  import apb_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ack,
  output logic [1:0]      req_done,
  output logic            req_err,
  output logic [DW-1:0]   req_rdata,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  localparam int CW = $clog2(TIMEOUT + 2);

  apb_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic [1:0]     ack_q, ack_d;
  logic [1:0]     done_q, done_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic           pwrite_q, pwrite_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;

  logic [1:0]     grant;
  logic           any_req;
  logic           arb_en;
  logic           gidx;

  // Arbitration happens only where a new transfer may start.
  assign arb_en = (state_q == IDLE) || (state_q == ACCESS && PREADY);
  assign gidx   = grant[1];

  rr_arb2 u_arb (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .req_i    (req_valid),
    .enable_i (arb_en),
    .grant_o  (grant),
    .any_o    (any_req)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done_d    = owner_q ? 2'b10 : 2'b01;
          penable_d = 1'b0;
          psel_d    = 1'b0;
          state_d   = IDLE;
          if (!pwrite_q) rdata_d = PRDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT > 0 && cnt_d == CW'(TIMEOUT)) begin
            done_d    = owner_q ? 2'b10 : 2'b01;
            err_d     = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant overrides the idle/completion defaults above and launches SETUP.
    if (arb_en && any_req) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      owner_d   = gidx;
      ack_d     = grant;
      cnt_d     = '0;
      pwrite_d  = req_write[gidx];
      paddr_d   = gidx ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
      pwdata_d  = gidx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ack_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
